// File: rtl/interrupt_stack_sequencer.sv
// rtl/interrupt_stack_sequencer.sv - 6502 interrupt entry (NMI/IRQ/BRK) and RTI stack sequencer
// Drives register-file write ports and a single-port synchronous memory; outputs decode from state.
module interrupt_stack_sequencer #(
    parameter logic [7:0]  STACK_PAGE = 8'h01,
    parameter logic [15:0] NMI_VECTOR = 16'hFFFA,
    parameter logic [15:0] IRQ_VECTOR = 16'hFFFE
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        sync,
    input  logic        nmi_n,
    input  logic        irq_n,
    input  logic        brk_req,
    input  logic        rti_req,
    input  logic [7:0]  sp_cur,
    input  logic [15:0] pc_cur,
    input  logic [7:0]  ps_cur,
    input  logic [7:0]  mem_rdata,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_we,
    output logic        we_sp,
    output logic        we_pc,
    output logic        we_ps,
    output logic [7:0]  sp_out,
    output logic [15:0] pc_out,
    output logic [7:0]  flags_out,
    output logic        busy,
    output logic        done
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_PUSH_PCH,
        S_PUSH_PCL,
        S_PUSH_PS,
        S_VEC_LO,
        S_VEC_HI,
        S_LOAD_PC,
        S_POP_A,
        S_POP_PS,
        S_POP_PCL,
        S_POP_PCH
    } state_t;

    typedef enum logic [1:0] {
        K_NMI,
        K_IRQ,
        K_BRK
    } kind_t;

    state_t      r_state;
    kind_t       r_kind;
    logic        r_nmi_d;
    logic        r_nmi_pending;
    logic [7:0]  r_pcl_lat;

    logic        w_nmi_edge;
    logic        w_accept_nmi;
    logic [7:0]  w_sp_dec;
    logic [7:0]  w_sp_inc;
    logic [15:0] w_vec;

    assign w_nmi_edge   = r_nmi_d & ~nmi_n;
    assign w_accept_nmi = (r_state == S_IDLE) && sync && r_nmi_pending;
    assign w_sp_dec     = sp_cur - 8'd1;
    assign w_sp_inc     = sp_cur + 8'd1;
    assign w_vec        = (r_kind == K_NMI) ? NMI_VECTOR : IRQ_VECTOR;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_kind        <= K_NMI;
            r_nmi_d       <= 1'b1;
            r_nmi_pending <= 1'b0;
            r_pcl_lat     <= 8'h00;
        end else begin
            r_nmi_d <= nmi_n;
            // A fresh edge on the acceptance cycle must survive the clear.
            if (w_nmi_edge) begin
                r_nmi_pending <= 1'b1;
            end else if (w_accept_nmi) begin
                r_nmi_pending <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (sync) begin
                        if (r_nmi_pending) begin
                            r_kind  <= K_NMI;
                            r_state <= S_PUSH_PCH;
                        end else if (brk_req) begin
                            r_kind  <= K_BRK;
                            r_state <= S_PUSH_PCH;
                        end else if (!irq_n && !ps_cur[2]) begin
                            r_kind  <= K_IRQ;
                            r_state <= S_PUSH_PCH;
                        end else if (rti_req) begin
                            r_state <= S_POP_A;
                        end
                    end
                end
                S_PUSH_PCH: r_state <= S_PUSH_PCL;
                S_PUSH_PCL: r_state <= S_PUSH_PS;
                S_PUSH_PS:  r_state <= S_VEC_LO;
                S_VEC_LO:   r_state <= S_VEC_HI;
                S_VEC_HI: begin
                    r_pcl_lat <= mem_rdata;
                    r_state   <= S_LOAD_PC;
                end
                S_LOAD_PC:  r_state <= S_IDLE;
                S_POP_A:    r_state <= S_POP_PS;
                S_POP_PS:   r_state <= S_POP_PCL;
                S_POP_PCL: begin
                    r_pcl_lat <= mem_rdata;
                    r_state   <= S_POP_PCH;
                end
                S_POP_PCH:  r_state <= S_IDLE;
                default:    r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        mem_addr  = 16'h0000;
        mem_wdata = 8'h00;
        mem_we    = 1'b0;
        we_sp     = 1'b0;
        we_pc     = 1'b0;
        we_ps     = 1'b0;
        sp_out    = 8'h00;
        pc_out    = 16'h0000;
        flags_out = 8'h00;
        busy      = (r_state != S_IDLE);
        done      = 1'b0;
        case (r_state)
            S_PUSH_PCH: begin
                mem_addr  = {STACK_PAGE, sp_cur};
                mem_wdata = pc_cur[15:8];
                mem_we    = 1'b1;
                sp_out    = w_sp_dec;
                we_sp     = 1'b1;
            end
            S_PUSH_PCL: begin
                mem_addr  = {STACK_PAGE, sp_cur};
                mem_wdata = pc_cur[7:0];
                mem_we    = 1'b1;
                sp_out    = w_sp_dec;
                we_sp     = 1'b1;
            end
            S_PUSH_PS: begin
                mem_addr  = {STACK_PAGE, sp_cur};
                mem_wdata = {ps_cur[7:6], 1'b1, (r_kind == K_BRK), ps_cur[3:0]};
                mem_we    = 1'b1;
                sp_out    = w_sp_dec;
                we_sp     = 1'b1;
                flags_out = ps_cur | 8'h04;
                we_ps     = 1'b1;
            end
            S_VEC_LO: mem_addr = w_vec;
            S_VEC_HI: mem_addr = w_vec + 16'd1;
            S_LOAD_PC: begin
                pc_out = {mem_rdata, r_pcl_lat};
                we_pc  = 1'b1;
                done   = 1'b1;
            end
            S_POP_A, S_POP_PCL: begin
                mem_addr = {STACK_PAGE, w_sp_inc};
                sp_out   = w_sp_inc;
                we_sp    = 1'b1;
            end
            S_POP_PS: begin
                mem_addr  = {STACK_PAGE, w_sp_inc};
                sp_out    = w_sp_inc;
                we_sp     = 1'b1;
                flags_out = (mem_rdata & 8'hEF) | 8'h20;
                we_ps     = 1'b1;
            end
            S_POP_PCH: begin
                pc_out = {mem_rdata, r_pcl_lat};
                we_pc  = 1'b1;
                done   = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_interrupt_stack_sequencer.sv
// tb/tb_interrupt_stack_sequencer.sv - self-checking bench for interrupt_stack_sequencer
// Behavioural register file and memory around the DUT; expectations from a byte-level stack model.
module tb_interrupt_stack_sequencer;

    localparam int K_NMI = 0;
    localparam int K_IRQ = 1;
    localparam int K_BRK = 2;
    localparam int K_RTI = 3;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        sync = 1'b0;
    logic        nmi_n = 1'b1;
    logic        irq_n = 1'b1;
    logic        brk_req = 1'b0;
    logic        rti_req = 1'b0;
    logic [7:0]  rf_sp = 8'h00;
    logic [15:0] rf_pc = 16'h0000;
    logic [7:0]  rf_ps = 8'h00;
    logic [7:0]  mem_rdata = 8'h00;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic        we_sp, we_pc, we_ps;
    logic [7:0]  sp_out;
    logic [15:0] pc_out;
    logic [7:0]  flags_out;
    logic        busy, done;

    logic        ld_en = 1'b0;
    logic [7:0]  ld_sp = 8'h00;
    logic [15:0] ld_pc = 16'h0000;
    logic [7:0]  ld_ps = 8'h00;
    logic        pl_en = 1'b0;
    logic [15:0] pl_addr = 16'h0000;
    logic [7:0]  pl_data = 8'h00;

    logic [7:0]  mem   [0:65535];
    bit   [7:0]  m_mem [0:65535];
    logic [7:0]  m_sp;
    logic [15:0] m_pc;
    logic [7:0]  m_ps;

    int n_vec = 0;
    int n_err = 0;

    interrupt_stack_sequencer dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .sync      (sync),
        .nmi_n     (nmi_n),
        .irq_n     (irq_n),
        .brk_req   (brk_req),
        .rti_req   (rti_req),
        .sp_cur    (rf_sp),
        .pc_cur    (rf_pc),
        .ps_cur    (rf_ps),
        .mem_rdata (mem_rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .we_sp     (we_sp),
        .we_pc     (we_pc),
        .we_ps     (we_ps),
        .sp_out    (sp_out),
        .pc_out    (pc_out),
        .flags_out (flags_out),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ld_en) begin
            rf_sp <= ld_sp;
            rf_pc <= ld_pc;
            rf_ps <= ld_ps;
        end else begin
            if (we_sp) rf_sp <= sp_out;
            if (we_pc) rf_pc <= pc_out;
            if (we_ps) rf_ps <= flags_out;
        end
    end

    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic poke(input logic [15:0] a, input logic [7:0] d);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        m_mem[a] = d;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    task automatic set_rf(input logic [7:0] sp, input logic [15:0] pc, input logic [7:0] ps);
        ld_en = 1'b1; ld_sp = sp; ld_pc = pc; ld_ps = ps;
        m_sp = sp; m_pc = pc; m_ps = ps;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    // Raises sync, logs every busy cycle, then compares against the stack model.
    task automatic run_seq(input int kind, input bit drop, input int nmi_at);
        logic [15:0] lg_addr [1:8];
        logic        lg_we   [1:8];
        logic [7:0]  lg_wd   [1:8];
        logic [7:0]  sp0, sa, pushed;
        logic [15:0] vec;
        logic [7:0]  exp_wd [1:3];
        int cyc, done_at, n_exp;
        for (int i = 1; i <= 8; i++) begin
            lg_addr[i] = 16'h0; lg_we[i] = 1'b0; lg_wd[i] = 8'h0;
        end
        n_exp = (kind == K_RTI) ? 4 : 6;
        sync = 1'b1;
        cyc = 0; done_at = 0;
        for (int t = 0; t < 24 && done_at == 0; t++) begin
            @(negedge clk);
            if (busy) begin
                cyc++;
                if (cyc <= 8) begin
                    lg_addr[cyc] = mem_addr; lg_we[cyc] = mem_we; lg_wd[cyc] = mem_wdata;
                end
                if (done) done_at = cyc;
                if (cyc == nmi_at) nmi_n = 1'b0;
                if (cyc == nmi_at + 1) nmi_n = 1'b1;
            end
        end
        if (drop) begin
            sync = 1'b0; brk_req = 1'b0; rti_req = 1'b0; irq_n = 1'b1; nmi_n = 1'b1;
        end
        @(negedge clk);
        chk("idle_after", 32'(busy), 32'd0);
        chk("done_cycle", 32'(done_at), 32'(n_exp));
        chk("busy_len", 32'(cyc), 32'(n_exp));
        sp0 = m_sp;
        if (kind == K_RTI) begin
            for (int i = 1; i <= 4; i++) chk("rti_we", 32'(lg_we[i]), 32'd0);
            for (int i = 1; i <= 3; i++) begin
                sa = sp0 + 8'(i);
                chk("pop_addr", 32'(lg_addr[i]), 32'({8'h01, sa}));
            end
            sa = sp0 + 8'd1;
            m_ps = (m_mem[{8'h01, sa}] & 8'hEF) | 8'h20;
            sa = sp0 + 8'd2;
            m_pc[7:0] = m_mem[{8'h01, sa}];
            sa = sp0 + 8'd3;
            m_pc[15:8] = m_mem[{8'h01, sa}];
            m_sp = sp0 + 8'd3;
        end else begin
            pushed = {m_ps[7:6], 1'b1, (kind == K_BRK), m_ps[3:0]};
            vec = (kind == K_NMI) ? 16'hFFFA : 16'hFFFE;
            exp_wd[1] = m_pc[15:8]; exp_wd[2] = m_pc[7:0]; exp_wd[3] = pushed;
            for (int i = 1; i <= 3; i++) begin
                sa = sp0 - 8'(i - 1);
                chk("push_we", 32'(lg_we[i]), 32'd1);
                chk("push_addr", 32'(lg_addr[i]), 32'({8'h01, sa}));
                chk("push_data", 32'(lg_wd[i]), 32'(exp_wd[i]));
                m_mem[{8'h01, sa}] = exp_wd[i];
            end
            for (int i = 4; i <= 6; i++) chk("vec_we", 32'(lg_we[i]), 32'd0);
            chk("vec_lo", 32'(lg_addr[4]), 32'(vec));
            chk("vec_hi", 32'(lg_addr[5]), 32'(vec + 16'd1));
            m_sp = sp0 - 8'd3;
            m_ps = m_ps | 8'h04;
            m_pc = {m_mem[vec + 16'd1], m_mem[vec]};
        end
        chk("rf_sp", 32'(rf_sp), 32'(m_sp));
        chk("rf_pc", 32'(rf_pc), 32'(m_pc));
        chk("rf_ps", 32'(rf_ps), 32'(m_ps));
    endtask

    initial begin
        int n_busy, n_we, kind;
        logic [7:0]  r_sp, r_ps;
        logic [15:0] r_pc;

        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        m_sp = 8'h00; m_pc = 16'h0000; m_ps = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_we", 32'({we_sp, we_pc, we_ps, done}), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_data", 32'({sp_out, pc_out, flags_out, mem_wdata}), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // IRQ entry from SP=FF
        poke(16'hFFFE, 8'h00); poke(16'hFFFF, 8'h80);
        set_rf(8'hFF, 16'h1234, 8'h20);
        irq_n = 1'b0;
        run_seq(K_IRQ, 1'b1, 0);
        chk("t1_sp", 32'(rf_sp), 32'h00FC);
        chk("t1_ps", 32'(rf_ps), 32'h0024);
        chk("t1_pc", 32'(rf_pc), 32'h8000);
        chk("t1_m1fd", 32'(mem[16'h01FD]), 32'h20);

        // Masked IRQ, then NMI edge
        set_rf(8'hF0, 16'h4321, 8'h24);
        irq_n = 1'b0; sync = 1'b1; n_busy = 0; n_we = 0;
        repeat (20) begin
            @(negedge clk);
            if (busy) n_busy++;
            if (mem_we) n_we++;
        end
        chk("mask_busy", 32'(n_busy), 32'd0);
        chk("mask_we", 32'(n_we), 32'd0);
        poke(16'hFFFA, 8'h11); poke(16'hFFFB, 8'h22);
        nmi_n = 1'b0;
        run_seq(K_NMI, 1'b1, 0);
        chk("t2_pc", 32'(rf_pc), 32'h2211);

        // BRK entry
        set_rf(8'hC0, 16'h0300, 8'h20);
        brk_req = 1'b1;
        run_seq(K_BRK, 1'b1, 0);
        chk("t3_pushed", 32'(mem[16'h01BE]), 32'h30);

        // NMI pending beats held BRK; BRK follows
        set_rf(8'hA0, 16'h0456, 8'h00);
        nmi_n = 1'b0; @(negedge clk); nmi_n = 1'b1; @(negedge clk);
        brk_req = 1'b1;
        run_seq(K_NMI, 1'b0, 0);
        run_seq(K_BRK, 1'b1, 0);

        // RTI
        set_rf(8'hFC, 16'h0000, 8'h00);
        poke(16'h01FD, 8'hFF); poke(16'h01FE, 8'h78); poke(16'h01FF, 8'h56);
        rti_req = 1'b1;
        run_seq(K_RTI, 1'b1, 0);
        chk("t4_ps", 32'(rf_ps), 32'hEF);
        chk("t4_pc", 32'(rf_pc), 32'h5678);
        chk("t4_sp", 32'(rf_sp), 32'hFF);

        // RTI wrap
        set_rf(8'hFE, 16'h0000, 8'h00);
        poke(16'h01FF, 8'h03); poke(16'h0100, 8'hCD); poke(16'h0101, 8'hAB);
        rti_req = 1'b1;
        run_seq(K_RTI, 1'b1, 0);
        chk("t4w_sp", 32'(rf_sp), 32'h01);
        chk("t4w_pc", 32'(rf_pc), 32'hABCD);

        // Push wrap
        set_rf(8'h01, 16'h9ABC, 8'h20);
        irq_n = 1'b0;
        run_seq(K_IRQ, 1'b1, 0);
        chk("t5_sp", 32'(rf_sp), 32'hFE);

        // NMI edge while busy is serviced after done
        set_rf(8'h70, 16'h5555, 8'h00);
        brk_req = 1'b1;
        run_seq(K_BRK, 1'b1, 3);
        run_seq(K_NMI, 1'b1, 0);

        // Reset during PUSH_PCL with an NMI edge pending
        set_rf(8'h80, 16'hABCD, 8'h20);
        poke(16'h017F, 8'h5A);
        irq_n = 1'b0; sync = 1'b1;
        for (int t = 0; t < 10 && !busy; t++) @(negedge clk);
        chk("rst_seq_start", 32'(busy), 32'd1);
        nmi_n = 1'b0;
        @(negedge clk);
        nmi_n = 1'b1;
        reset_n = 1'b0;
        #1;
        chk("rst_mid_we", 32'({mem_we, we_sp, we_pc, we_ps}), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        irq_n = 1'b1; sync = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        sync = 1'b1; n_busy = 0;
        repeat (5) begin
            @(negedge clk);
            if (busy) n_busy++;
        end
        sync = 1'b0;
        chk("rst_no_pending", 32'(n_busy), 32'd0);
        chk("rst_sp", 32'(rf_sp), 32'h7F);
        chk("rst_nowrite", 32'(mem[16'h017F]), 32'(m_mem[16'h017F]));
        m_mem[16'h0180] = 8'hAB;

        // Randomized sequences
        for (int it = 0; it < 40; it++) begin
            kind = int'($urandom_range(0, 3));
            r_sp = 8'($urandom); r_pc = 16'($urandom); r_ps = 8'($urandom);
            if (kind == K_IRQ) r_ps[2] = 1'b0;
            set_rf(r_sp, r_pc, r_ps);
            if (kind == K_RTI) begin
                for (int i = 1; i <= 3; i++) poke({8'h01, r_sp + 8'(i)}, 8'($urandom));
                rti_req = 1'b1;
            end else begin
                poke((kind == K_NMI) ? 16'hFFFA : 16'hFFFE, 8'($urandom));
                poke((kind == K_NMI) ? 16'hFFFB : 16'hFFFF, 8'($urandom));
                if (kind == K_NMI) nmi_n = 1'b0;
                else if (kind == K_IRQ) irq_n = 1'b0;
                else brk_req = 1'b1;
            end
            run_seq(kind, 1'b1, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
